// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Stack guarding is selected by the PC_STACK_GUARD_EN macro.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        PC_INC    = 3'd0,
        PC_HOLD   = 3'd1,
        PC_JUMP   = 3'd2,
        PC_BRANCH = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_op_t;

    localparam logic [63:0] PC_RESET_VALUE = '0;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular return-address stack (LIFO).
// PC_STACK_GUARD_EN blocks push when full and pop when empty.
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Push,
    input  logic                     Pop,
    input  logic [WIDTH-1:0]         PushData,
    output logic [WIDTH-1:0]         TopData,
    output logic [$clog2(DEPTH):0]   Level,
    output logic                     Full,
    output logic                     Empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign Full   = (Level == LW'(DEPTH));
    assign Empty  = (Level == '0);
    assign rd_ptr = ptr - AW'(1);
    assign TopData = mem[rd_ptr];

`ifdef PC_STACK_GUARD_EN
    assign do_push = Push & ~Full;
    assign do_pop  = Pop & ~Empty;
`else
    assign do_push = Push;
    assign do_pop  = Pop;
`endif

    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[ptr] <= PushData;
        end
    end

    // ptr always names the next free slot; wrapping overwrites the oldest
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr   <= '0;
            Level <= '0;
        end else if (do_push) begin
            ptr <= ptr + AW'(1);
            if (!Full) begin
                Level <= Level + LW'(1);
            end
        end else if (do_pop) begin
            ptr <= rd_ptr;
            if (!Empty) begin
                Level <= Level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with return-address stack.
// Define PC_STACK_GUARD_EN for overflow/underflow protection and Fault.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int OFFSET_WIDTH = 9,
    parameter int STACK_DEPTH  = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  pc_op_t                        Op,
    input  logic [WIDTH-1:0]              LoadValue,
    input  logic [OFFSET_WIDTH-1:0]       Offset,
    output logic [WIDTH-1:0]              CounterValue,
    output logic [$clog2(STACK_DEPTH):0]  StackLevel,
    output logic                          Fault
);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] offset_ext;
    logic [WIDTH-1:0] top_data;
    logic             push;
    logic             pop;
    logic             fault_set;
    logic             full;
    logic             empty;

    assign pc_inc     = CounterValue + WIDTH'(1);
    assign offset_ext = {{(WIDTH-OFFSET_WIDTH){Offset[OFFSET_WIDTH-1]}}, Offset};

    always_comb begin
        pc_d      = CounterValue;
        push      = 1'b0;
        pop       = 1'b0;
        fault_set = 1'b0;
        unique case (Op)
            PC_INC:    pc_d = pc_inc;
            PC_HOLD:   pc_d = CounterValue;
            PC_JUMP:   pc_d = LoadValue;
            PC_BRANCH: pc_d = CounterValue + offset_ext;
            PC_CALL: begin
`ifdef PC_STACK_GUARD_EN
                if (full) begin
                    fault_set = 1'b1;
                end else begin
                    push = 1'b1;
                    pc_d = LoadValue;
                end
`else
                push = 1'b1;
                pc_d = LoadValue;
`endif
            end
            PC_RET: begin
`ifdef PC_STACK_GUARD_EN
                if (empty) begin
                    fault_set = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = top_data;
                end
`else
                pop  = 1'b1;
                pc_d = top_data;
`endif
            end
            default:   pc_d = CounterValue;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            CounterValue <= WIDTH'(PC_RESET_VALUE);
        end else begin
            CounterValue <= pc_d;
        end
    end

`ifdef PC_STACK_GUARD_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Fault <= 1'b0;
        end else if (fault_set) begin
            Fault <= 1'b1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = full ^ empty ^ fault_set;
    assign Fault = 1'b0;
`endif

    return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clock    (Clock),
        .Reset    (Reset),
        .Push     (push),
        .Pop      (pop),
        .PushData (pc_inc),
        .TopData  (top_data),
        .Level    (StackLevel),
        .Full     (full),
        .Empty    (empty)
    );

endmodule
